// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10,
        ABORT = 2'b11
    } state_t;

    localparam int unsigned REQ_ID_W            = 1;
    localparam int unsigned WDOG_CYCLES_DEFAULT = 64;

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// Bus between the arbiter (master) and the external multiplier (slave).
interface mul_arbiter_if;

    logic        mul_start_o;
    logic        mul_annul_o;
    logic        mul_signed_o;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;

    modport master (
        output mul_start_o, mul_annul_o, mul_signed_o, mul_op1_o, mul_op2_o,
        input  mul_result_i, mul_ready_i
    );

    modport slave (
        input  mul_start_o, mul_annul_o, mul_signed_o, mul_op1_o, mul_op2_o,
        output mul_result_i, mul_ready_i
    );

endinterface

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin grant; the priority pointer moves only when a grant is taken.
module rr_arb2
    import mul_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_any,
    output req_id_t    gnt_id
);

    // Holds the requester that wins a tie; resets to 0 so requester 0 goes first.
    req_id_t prio;

    always_comb begin
        gnt_any = |req;
        case (req)
            2'b10:   gnt_id = req_id_t'(1);
            2'b11:   gnt_id = prio;
            default: gnt_id = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= '0;
        end else if (take) begin
            prio <= ~gnt_id;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external multiplier between two requesters with flush and round-robin.
// Optional watchdog abort enabled by defining MUL_ARB_WATCHDOG_EN.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_signed,
    input  logic [31:0]   req0_a,
    input  logic [31:0]   req0_b,
    output logic          req0_accept,
    output logic          req0_done,
    output logic          req0_err,
    input  logic          req1_valid,
    input  logic          req1_signed,
    input  logic [31:0]   req1_a,
    input  logic [31:0]   req1_b,
    output logic          req1_accept,
    output logic          req1_done,
    output logic          req1_err,
    input  logic          flush0,
    output logic [63:0]   res_o,
    output logic          busy_o,
    mul_arbiter_if.master mul
);

    state_t      state;
    req_id_t     owner;
    logic        op_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] res_q;
    logic [1:0]  accept_q;
    logic [1:0]  done_q;
    logic        start_q;
    logic        annul_q;
    logic        gnt_any;
    req_id_t     gnt_id;
    logic        take;

    assign take = (state == IDLE) && gnt_any;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid & ~flush0}),
        .take    (take),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

`ifdef MUL_ARB_WATCHDOG_EN
    logic [1:0]  err_q;
    logic [31:0] wdog_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            op_signed <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            accept_q  <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
`ifdef MUL_ARB_WATCHDOG_EN
            err_q     <= '0;
            wdog_cnt  <= '0;
`endif
        end else begin
            accept_q <= '0;
            done_q   <= '0;
            annul_q  <= 1'b0;
`ifdef MUL_ARB_WATCHDOG_EN
            err_q    <= '0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        accept_q[gnt_id] <= 1'b1;
                        owner            <= gnt_id;
                        op_signed        <= (gnt_id != '0) ? req1_signed : req0_signed;
                        op_a             <= (gnt_id != '0) ? req1_a : req0_a;
                        op_b             <= (gnt_id != '0) ? req1_b : req0_b;
                        start_q          <= 1'b1;
                        state            <= BUSY;
`ifdef MUL_ARB_WATCHDOG_EN
                        wdog_cnt         <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Flush outranks a simultaneous ready: the product is dropped.
                    if (flush0 && owner == '0) begin
                        annul_q <= 1'b1;
                        start_q <= 1'b0;
                        state   <= DRAIN;
                    end else if (mul.mul_ready_i) begin
                        res_q         <= mul.mul_result_i;
                        done_q[owner] <= 1'b1;
                        start_q       <= 1'b0;
                        state         <= DRAIN;
                    end
`ifdef MUL_ARB_WATCHDOG_EN
                    else if (wdog_cnt == WDOG_CYCLES - 1) begin
                        annul_q      <= 1'b1;
                        err_q[owner] <= 1'b1;
                        start_q      <= 1'b0;
                        state        <= ABORT;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1;
                    end
`endif
                end
                ABORT: state <= DRAIN;
                DRAIN: begin
                    if (!mul.mul_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req0_accept      = accept_q[0];
    assign req1_accept      = accept_q[1];
    assign req0_done        = done_q[0];
    assign req1_done        = done_q[1];
`ifdef MUL_ARB_WATCHDOG_EN
    assign req0_err         = err_q[0];
    assign req1_err         = err_q[1];
`else
    assign req0_err         = 1'b0;
    assign req1_err         = 1'b0;
`endif
    assign res_o            = res_q;
    assign busy_o           = (state != IDLE);
    assign mul.mul_start_o  = start_q;
    assign mul.mul_annul_o  = annul_q;
    assign mul.mul_signed_o = op_signed;
    assign mul.mul_op1_o    = op_a;
    assign mul.mul_op2_o    = op_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural external multiplier.
`timescale 1ns/1ps
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_signed = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0;
    logic        req1_valid = 1'b0, req1_signed = 1'b0;
    logic [31:0] req1_a = '0, req1_b = '0;
    logic        flush0 = 1'b0;
    logic        req0_accept, req0_done, req0_err;
    logic        req1_accept, req1_done, req1_err;
    logic [63:0] res_o;
    logic        busy_o;

    always #5 clk = ~clk;

    mul_arbiter_if mif ();

    mul_arbiter #(.WDOG_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_signed (req0_signed),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_accept (req0_accept),
        .req0_done   (req0_done),
        .req0_err    (req0_err),
        .req1_valid  (req1_valid),
        .req1_signed (req1_signed),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_accept (req1_accept),
        .req1_done   (req1_done),
        .req1_err    (req1_err),
        .flush0      (flush0),
        .res_o       (res_o),
        .busy_o      (busy_o),
        .mul         (mif.master)
    );

    // External multiplier: ready 'lat' cycles after start, held until start drops.
    int unsigned lat  = 2;
    logic        hang = 1'b0;
    int unsigned mcnt;
    logic        mrdy;
    logic [63:0] mres;

    always @(posedge clk) begin
        if (rst || mif.mul_annul_o || !mif.mul_start_o) begin
            mrdy <= 1'b0;
            mcnt <= 0;
        end else if (!hang && mcnt + 1 >= lat) begin
            mrdy <= 1'b1;
            mres <= mif.mul_signed_o
                  ? 64'($signed({{32{mif.mul_op1_o[31]}}, mif.mul_op1_o}) *
                        $signed({{32{mif.mul_op2_o[31]}}, mif.mul_op2_o}))
                  : {32'b0, mif.mul_op1_o} * {32'b0, mif.mul_op2_o};
        end else begin
            mcnt <= mcnt + 1;
        end
    end
    assign mif.mul_ready_i  = mrdy;
    assign mif.mul_result_i = mres;

    typedef struct {
        logic        is_err;
        logic        id;
        logic [63:0] res;
    } exp_t;

    exp_t exp_q[$];
    logic acc_q[$];
    int   checks = 0;
    int   passes = 0;
    int   annul_cnt = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endfunction

    function automatic void push_done(input logic id, input logic [63:0] res);
        exp_t e;
        e.is_err = 1'b0; e.id = id; e.res = res;
        exp_q.push_back(e);
    endfunction

    // Monitor: pops expected accepts and completion pulses as the DUT presents them.
    always @(negedge clk) begin
        logic [3:0] p;
        logic [3:0] want;
        exp_t       e;
        logic       a;
        if (mif.mul_annul_o) annul_cnt++;
        if (req0_accept || req1_accept) begin
            if (req0_accept && req1_accept) check("accept_onehot", {req1_accept, req0_accept}, 2'b01);
            else if (acc_q.size() == 0) check("accept_unexpected", {req1_accept, req0_accept}, 2'b00);
            else begin
                a = acc_q.pop_front();
                check("accept_id", req1_accept, a);
            end
        end
        p = {req1_err, req0_err, req1_done, req0_done};
        if (p != 4'b0000) begin
            if ($countones(p) != 1) check("pulse_onehot", p, 4'b0000);
            else if (exp_q.size() == 0) check("pulse_unexpected", p, 4'b0000);
            else begin
                e = exp_q.pop_front();
                want = e.is_err ? (e.id ? 4'b1000 : 4'b0100) : (e.id ? 4'b0010 : 4'b0001);
                check("pulse_kind", p, want);
                if (!e.is_err) check("result", res_o, e.res);
            end
        end
    end

    task automatic drive(input int id, input logic v, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_valid = v; req0_signed = sgn; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_signed = sgn; req1_a = a; req1_b = b;
        end
    endtask

    // Holds a request valid until it has been accepted n times (bounded).
    task automatic hold_req(input int id, input int n, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b, input string name);
        int got = 0;
        drive(id, 1'b1, sgn, a, b);
        for (int i = 0; i < 400 && got < n; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_accept : req1_accept) got++;
        end
        drive(id, 1'b0, sgn, a, b);
        check(name, got, n);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy_o; i++) @(negedge clk);
        check(name, busy_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, {req0_accept, req1_accept, req0_done, req1_done, req0_err, req1_err}, '0);
        check({tag, "_ctrl"}, {busy_o, mif.mul_start_o, mif.mul_annul_o, mif.mul_signed_o}, '0);
        check({tag, "_res"}, res_o, '0);
        check({tag, "_ops"}, {mif.mul_op1_o, mif.mul_op2_o}, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic seen;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Signed 7 * -3
        lat = 2;
        acc_q.push_back(1'b0);
        push_done(1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        hold_req(0, 1, 1'b1, 32'd7, 32'hFFFF_FFFD, "t1_accept");
        check("t1_ops_latched", {mif.mul_signed_o, mif.mul_op1_o, mif.mul_op2_o}, {1'b1, 32'd7, 32'hFFFF_FFFD});
        wait_idle("t1_idle");
        check("t1_drained", exp_q.size(), 0);

        // Unsigned max * 2 on requester 1
        acc_q.push_back(1'b1);
        push_done(1'b1, 64'h0000_0001_FFFF_FFFE);
        hold_req(1, 1, 1'b0, 32'hFFFF_FFFF, 32'd2, "t2_accept");
        wait_idle("t2_idle");
        check("t2_drained", exp_q.size(), 0);

        // Contention: alternate 0,1,0,1
        lat = 1;
        acc_q.push_back(1'b0); acc_q.push_back(1'b1); acc_q.push_back(1'b0); acc_q.push_back(1'b1);
        push_done(1'b0, 64'd15); push_done(1'b1, 64'd24);
        push_done(1'b0, 64'd15); push_done(1'b1, 64'd24);
        fork
            hold_req(0, 2, 1'b0, 32'd3, 32'd5, "t3_req0_accepts");
            hold_req(1, 2, 1'b0, 32'd4, 32'd6, "t3_req1_accepts");
        join
        wait_idle("t3_idle");
        check("t3_drained", exp_q.size(), 0);

        // Flush in the 5th BUSY cycle; pending req1 served afterwards
        lat = 8;
        annul_cnt = 0;
        acc_q.push_back(1'b0); acc_q.push_back(1'b1);
        push_done(1'b1, 64'd6);
        hold_req(0, 1, 1'b0, 32'd9, 32'd9, "t4_req0_accept");
        drive(1, 1'b1, 1'b0, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        hold_req(1, 1, 1'b0, 32'd2, 32'd3, "t4_req1_accept");
        check("t4_annul_pulses", annul_cnt, 1);
        wait_idle("t4_idle");
        check("t4_drained", exp_q.size(), 0);

        // Flush and ready together: result discarded
        lat = 3;
        acc_q.push_back(1'b0);
        hold_req(0, 1, 1'b0, 32'd5, 32'd5, "t5_accept");
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (mif.mul_ready_i) seen = 1'b1;
            else @(negedge clk);
        end
        check("t5_ready_seen", seen, 1'b1);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        wait_idle("t5_idle");
        check("t5_res_held", res_o, 64'd6);

`ifdef MUL_ARB_WATCHDOG_EN
        // Watchdog: multiplier never answers
        begin
            exp_t e;
            hang = 1'b1;
            acc_q.push_back(1'b0);
            e.is_err = 1'b1; e.id = 1'b0; e.res = '0;
            exp_q.push_back(e);
            hold_req(0, 1, 1'b0, 32'd1, 32'd1, "t6_accept");
            n = 0;
            for (int i = 0; i < 100 && !req0_err; i++) begin
                @(negedge clk);
                n++;
            end
            check("t6_err_delay", n, 8);
            hang = 1'b0;
            wait_idle("t6_idle");
            check("t6_drained", exp_q.size(), 0);
        end
`endif

        // Reset mid-BUSY
        lat = 10;
        acc_q.push_back(1'b1);
        hold_req(1, 1, 1'b0, 32'd3, 32'd3, "t7_accept");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t7_reset");
        rst = 1'b0;
        @(negedge clk);

        // After reset requester 0 wins a tie again
        lat = 2;
        acc_q.push_back(1'b0); acc_q.push_back(1'b1);
        push_done(1'b0, 64'd1);
        push_done(1'b1, 64'h0000_0001_0000_0000);
        fork
            hold_req(0, 1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t8_req0_accept");
            hold_req(1, 1, 1'b0, 32'h0001_0000, 32'h0001_0000, "t8_req1_accept");
        join
        wait_idle("t8_idle");

        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("acc_queue_empty", acc_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
